ps2_voice_allocator: RTL
========================

PS2_VOICE_ALLOCATOR -- requirements
Module: ps2_voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 8: number of synthesizer voices driven.
REQ-002 SHALL have parameter ENV_DIV, default 24000: clk cycles per envelope tick.
REQ-003 SHALL have parameter ENV_STEP, default 64: volume change per envelope tick.
REQ-004 SHALL have parameter VOL_MAX, default 65535: full-scale voice volume.
REQ-005 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port ps2_key  input  11: [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode.
REQ-008 SHALL have port frequencies  output  NUM_VOICES x 32: per-voice note frequency in Hz, consumed by the synthesizer.
REQ-009 SHALL have port voice_volumes  output  NUM_VOICES x 32: per-voice envelope volume, 0..VOL_MAX.
REQ-010 SHALL have port voices_active  output  NUM_VOICES: bit set while voice is not IDLE.
REQ-011 SHALL have port note_drop  output  1: one-cycle pulse when a press finds no voice.

Function
REQ-012 SHALL detect a key event when ps2_key[10] differs from its registered copy; exactly one event per toggle.
REQ-013 SHALL map non-extended scancodes 1A,1B,22,23,21,2A,34,32,33,31,3B,3A,41 to note indices 0..12 with Hz 262,277,294,311,330,349,370,392,415,440,466,494,523.
REQ-014 SHALL ignore events with ps2_key[8]=1 or an unmapped scancode.
REQ-015 SHALL register the decoded event on the detecting edge and apply it to voice state on the next edge (outputs change 2 edges after toggle appears).
REQ-016 Per-voice FSM: IDLE, ATTACK, SUSTAIN, RELEASE; voice stores note index, frequency, volume.
REQ-017 Press: if any non-IDLE voice holds the same note, lowest such index enters ATTACK keeping current volume (retrigger); else lowest-index IDLE voice loads note, volume 0, enters ATTACK.
REQ-018 Press with no matching and no IDLE voice: handled per REQ-027/028.
REQ-019 Release: every voice holding that note in ATTACK or SUSTAIN enters RELEASE; release of an unheld note is a no-op.
REQ-020 Envelope tick: divider counts 0..ENV_DIV-1, tick on cycle at ENV_DIV-1, then wraps to 0.
REQ-021 On tick: ATTACK volume += ENV_STEP saturating at VOL_MAX, entering SUSTAIN when VOL_MAX reached; RELEASE volume -= ENV_STEP saturating at 0, entering IDLE when 0 reached; IDLE/SUSTAIN unchanged.
REQ-022 Tick and key event on same cycle: event wins for the affected voice; tick applies to all others.
REQ-023 frequencies SHALL be 0 for IDLE voices, else the stored note Hz; voices_active mirrors non-IDLE state combinationally from registers.
REQ-024 Arithmetic SHALL be 32-bit unsigned; no wrap of volume past 0 or VOL_MAX.

Reset
REQ-025 On reset: all voices IDLE, volumes 0, frequencies 0, voices_active 0, note_drop 0, divider 0, toggle copy loaded from ps2_key[10] (no event generated).
REQ-026 Reset mid-envelope SHALL take effect on the next edge, discarding any pending decoded event.

Configuration
REQ-027 With VOICE_STEAL_EN defined: press finding no IDLE/matching voice SHALL steal the lowest-index RELEASE voice (load note, volume 0, ATTACK); only if none is in RELEASE SHALL note_drop pulse.
REQ-028 Without VOICE_STEAL_EN: such a press SHALL be discarded and note_drop pulse for one cycle.

Verification
REQ-029 Reset, toggle ps2_key with {pressed=1,ext=0,code=1C->unmapped}, then code 15? no: press 0x1C -> no output change; press 0x1A -> voice0 freq 262, ATTACK, voices_active=0000_0001 two edges later.
REQ-030 ENV_DIV=4, ENV_STEP=16384, VOL_MAX=65535: hold press 0x1A -> volume 16384,32768,49152,65535 at ticks 1-4, SUSTAIN; release -> 49151..0 then IDLE, freq 0.
REQ-031 Press 8 distinct notes, press a 9th -> without VOICE_STEAL_EN note_drop pulses once, no voice changes.
REQ-032 VOICE_STEAL_EN: 8 notes held, release note on voice 3, press new note -> voice 3 reloads with new Hz, volume 0, ATTACK; note_drop stays 0.
REQ-033 Press 0x1A twice (second during RELEASE at volume 20000) -> same voice re-enters ATTACK from 20000, no second voice allocated.
REQ-034 Assert reset while voices in ATTACK with a toggle on same cycle -> all outputs 0 next edge, no event applied afterwards.

Source files
------------

// File: rtl/ps2_voice_allocator.sv
// PS/2 key events drive a polyphonic voice pool, with an attack/release volume envelope per voice.
// Build option VOICE_STEAL_EN: a press that finds no free voice takes over the lowest-index releasing voice.
module ps2_voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int ENV_DIV    = 24000,
    parameter int ENV_STEP   = 64,
    parameter int VOL_MAX    = 65535
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [10:0]                 ps2_key,
    output logic [NUM_VOICES-1:0][31:0] frequencies,
    output logic [NUM_VOICES-1:0][31:0] voice_volumes,
    output logic [NUM_VOICES-1:0]       voices_active,
    output logic                        note_drop
);
    // state   | meaning
    // IDLE    | voice free and silent
    // ATTACK  | key held, volume ramping up
    // SUSTAIN | key held, volume at VOL_MAX
    // RELEASE | key released, volume ramping down
    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} voice_state_t;

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    voice_state_t state_q [NUM_VOICES];
    voice_state_t state_d [NUM_VOICES];
    logic [3:0]   note_q  [NUM_VOICES];
    logic [3:0]   note_d  [NUM_VOICES];
    logic [31:0]  vol_q   [NUM_VOICES];
    logic [31:0]  vol_d   [NUM_VOICES];

    logic             toggle_q;
    logic             ev_valid_q;
    logic             ev_press_q;
    logic [3:0]       ev_note_q;
    logic [31:0]      div_q;
    logic             tick;
    logic [4:0]       decoded;
    logic             sel_found;
    logic             sel_load;
    logic [IDX_W-1:0] sel_idx;
    logic             drop_d;

    // Returns {mapped, note_index}.
    function automatic logic [4:0] decode_note(input logic [7:0] code);
        case (code)
            8'h1A:   return {1'b1, 4'd0};
            8'h1B:   return {1'b1, 4'd1};
            8'h22:   return {1'b1, 4'd2};
            8'h23:   return {1'b1, 4'd3};
            8'h21:   return {1'b1, 4'd4};
            8'h2A:   return {1'b1, 4'd5};
            8'h34:   return {1'b1, 4'd6};
            8'h32:   return {1'b1, 4'd7};
            8'h33:   return {1'b1, 4'd8};
            8'h31:   return {1'b1, 4'd9};
            8'h3B:   return {1'b1, 4'd10};
            8'h3A:   return {1'b1, 4'd11};
            8'h41:   return {1'b1, 4'd12};
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] note_hz(input logic [3:0] idx);
        case (idx)
            4'd0:    return 32'd262;
            4'd1:    return 32'd277;
            4'd2:    return 32'd294;
            4'd3:    return 32'd311;
            4'd4:    return 32'd330;
            4'd5:    return 32'd349;
            4'd6:    return 32'd370;
            4'd7:    return 32'd392;
            4'd8:    return 32'd415;
            4'd9:    return 32'd440;
            4'd10:   return 32'd466;
            4'd11:   return 32'd494;
            4'd12:   return 32'd523;
            default: return 32'd0;
        endcase
    endfunction

    assign decoded = decode_note(ps2_key[7:0]);
    assign tick    = (div_q == 32'(ENV_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            toggle_q   <= ps2_key[10];
            ev_valid_q <= 1'b0;
            ev_press_q <= 1'b0;
            ev_note_q  <= 4'd0;
            div_q      <= 32'd0;
            note_drop  <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                state_q[i] <= IDLE;
                note_q[i]  <= 4'd0;
                vol_q[i]   <= 32'd0;
            end
        end else begin
            toggle_q   <= ps2_key[10];
            ev_valid_q <= (ps2_key[10] != toggle_q) && !ps2_key[8] && decoded[4];
            ev_press_q <= ps2_key[9];
            ev_note_q  <= decoded[3:0];
            div_q      <= tick ? 32'd0 : div_q + 32'd1;
            note_drop  <= drop_d;
            state_q    <= state_d;
            note_q     <= note_d;
            vol_q      <= vol_d;
        end
    end

    // Voice selection for a press: matching note first, then a free voice, then (optionally) a releasing one.
    always_comb begin
        sel_found = 1'b0;
        sel_load  = 1'b0;
        sel_idx   = '0;
        drop_d    = 1'b0;
        if (ev_valid_q && ev_press_q) begin
            for (int i = NUM_VOICES - 1; i >= 0; i--) begin
                if (state_q[i] != IDLE && note_q[i] == ev_note_q) begin
                    sel_found = 1'b1;
                    sel_idx   = IDX_W'(i);
                end
            end
            if (!sel_found) begin
                for (int i = NUM_VOICES - 1; i >= 0; i--) begin
                    if (state_q[i] == IDLE) begin
                        sel_found = 1'b1;
                        sel_load  = 1'b1;
                        sel_idx   = IDX_W'(i);
                    end
                end
            end
`ifdef VOICE_STEAL_EN
            if (!sel_found) begin
                for (int i = NUM_VOICES - 1; i >= 0; i--) begin
                    if (state_q[i] == RELEASE) begin
                        sel_found = 1'b1;
                        sel_load  = 1'b1;
                        sel_idx   = IDX_W'(i);
                    end
                end
            end
`else
`endif
            drop_d = !sel_found;
        end
    end

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        vol_d   = vol_q;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (ev_valid_q && ev_press_q && sel_found && sel_idx == IDX_W'(i)) begin
                state_d[i] = ATTACK;
                if (sel_load) begin
                    note_d[i] = ev_note_q;
                    vol_d[i]  = 32'd0;
                end
            end else if (ev_valid_q && !ev_press_q && note_q[i] == ev_note_q &&
                         (state_q[i] == ATTACK || state_q[i] == SUSTAIN)) begin
                state_d[i] = RELEASE;
            end else if (tick) begin
                case (state_q[i])
                    ATTACK: begin
                        if ({1'b0, vol_q[i]} + 33'(ENV_STEP) >= 33'(VOL_MAX)) begin
                            vol_d[i]   = 32'(VOL_MAX);
                            state_d[i] = SUSTAIN;
                        end else begin
                            vol_d[i] = vol_q[i] + 32'(ENV_STEP);
                        end
                    end
                    RELEASE: begin
                        if (vol_q[i] <= 32'(ENV_STEP)) begin
                            vol_d[i]   = 32'd0;
                            state_d[i] = IDLE;
                        end else begin
                            vol_d[i] = vol_q[i] - 32'(ENV_STEP);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            voices_active[i] = (state_q[i] != IDLE);
            frequencies[i]   = (state_q[i] != IDLE) ? note_hz(note_q[i]) : 32'd0;
            voice_volumes[i] = vol_q[i];
        end
    end
endmodule
